apb_arbiter_2to1: RTL and testbench

- Two-requester APB arbiter: upstream ports s00 and s01, each driven by an independent APB requester, share one downstream APB port m00.
- Round-robin grant; one downstream transfer in flight at a time.
- Request fields are registered before they are replayed downstream, which adds fixed wait states to every upstream transfer.
- Sits between requesters and the existing APB NIC/peripheral fabric.

---
 rtl/apb_pkg.sv | 30 +++
 rtl/apb_arbiter_2to1_rr_arbiter2.sv | 39 +++
 rtl/apb_arbiter_2to1.sv | 167 ++++++++++++++++
 tb/tb_apb_arbiter_2to1.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB types and widths for the 2:1 arbiter and its round-robin helper.
// AW/DW here are the widths of the request struct.
package apb_pkg;

   localparam int APB_AW     = 32;
   localparam int APB_DW     = 32;
   localparam int APB_PSEL_W = 4;
   localparam int PPROT_W    = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_arb_state_e;

   typedef struct packed {
      logic [APB_AW-1:0]     paddr;
      logic [PPROT_W-1:0]    pprot;
      logic [APB_PSEL_W-1:0] pselx;
      logic                  pwrite;
      logic [APB_DW-1:0]     pwdata;
      logic [APB_DW/8-1:0]   pstrb;
   } apb_req_t;

   // A port is requesting when any of its select lines is set.
   function automatic logic psel_active(input logic [APB_PSEL_W-1:0] sel);
      return |sel;
   endfunction

endpackage

// File: rtl/apb_arbiter_2to1_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant, last winner remembered
// on 'advance'. After reset the last winner is port 1, so port 0 wins first.
module rr_arbiter2 (
   input  logic       clock,
   input  logic       resetn,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   logic [1:0] last_grant_q;
   logic [1:0] last_grant_d;

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant_q[0] ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (advance && (grant != 2'b00)) begin
         last_grant_d = grant;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         last_grant_q <= 2'b10;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/apb_arbiter_2to1.sv
// 2:1 APB arbiter: s00/s01 share m00, one transfer in flight, round-robin grant.
// Winning request is registered in IDLE, replayed as SETUP then ACCESS downstream.
module apb_arbiter_2to1
   import apb_pkg::*;
#(
   parameter int AW = APB_AW,   // must match apb_pkg::APB_AW
   parameter int DW = APB_DW    // must match apb_pkg::APB_DW
) (
   input  logic                  clock,
   input  logic                  resetn,

   input  logic [AW-1:0]         s00_paddr,
   input  logic [PPROT_W-1:0]    s00_pprot,
   input  logic [APB_PSEL_W-1:0] s00_pselx,
   input  logic                  s00_penable,
   input  logic                  s00_pwrite,
   input  logic [DW-1:0]         s00_pwdata,
   input  logic [DW/8-1:0]       s00_pstrb,
   output logic                  s00_pready,
   output logic                  s00_pslverr,
   output logic [DW-1:0]         s00_prdata,

   input  logic [AW-1:0]         s01_paddr,
   input  logic [PPROT_W-1:0]    s01_pprot,
   input  logic [APB_PSEL_W-1:0] s01_pselx,
   input  logic                  s01_penable,
   input  logic                  s01_pwrite,
   input  logic [DW-1:0]         s01_pwdata,
   input  logic [DW/8-1:0]       s01_pstrb,
   output logic                  s01_pready,
   output logic                  s01_pslverr,
   output logic [DW-1:0]         s01_prdata,

   output logic [AW-1:0]         m00_paddr,
   output logic [PPROT_W-1:0]    m00_pprot,
   output logic [APB_PSEL_W-1:0] m00_pselx,
   output logic                  m00_penable,
   output logic                  m00_pwrite,
   output logic [DW-1:0]         m00_pwdata,
   output logic [DW/8-1:0]       m00_pstrb,
   input  logic                  m00_pready,
   input  logic                  m00_pslverr,
   input  logic [DW-1:0]         m00_prdata
);

   apb_arb_state_e        state_q, state_d;
   apb_req_t              req_q, req_d;
   logic [1:0]            gnt_q, gnt_d;
   logic [APB_PSEL_W-1:0] psel_q, psel_d;
   logic                  penable_q, penable_d;

   apb_req_t   up_req [2];
   logic [1:0] arb_req;
   logic [1:0] arb_grant;
   logic       arb_advance;
   apb_req_t   win_req;

   logic          up_pready  [2];
   logic          up_pslverr [2];
   logic [DW-1:0] up_prdata  [2];

   // Upstream penable carries no information here: psel alone is the request.
   logic penable_unused;
   assign penable_unused = &{1'b0, s00_penable, s01_penable};

   assign up_req[0] = '{paddr: s00_paddr, pprot: s00_pprot, pselx: s00_pselx,
                        pwrite: s00_pwrite, pwdata: s00_pwdata, pstrb: s00_pstrb};
   assign up_req[1] = '{paddr: s01_paddr, pprot: s01_pprot, pselx: s01_pselx,
                        pwrite: s01_pwrite, pwdata: s01_pwdata, pstrb: s01_pstrb};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_req
         assign arb_req[gi] = psel_active(up_req[gi].pselx);
      end
   endgenerate

   assign arb_advance = (state_q == IDLE);
   assign win_req     = arb_grant[1] ? up_req[1] : up_req[0];

   rr_arbiter2 u_rr (
      .clock   (clock),
      .resetn  (resetn),
      .req     (arb_req),
      .advance (arb_advance),
      .grant   (arb_grant)
   );

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      gnt_d     = gnt_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      case (state_q)
         IDLE: begin
            if (arb_req != 2'b00) begin
               state_d = SETUP;
               req_d   = win_req;
               gnt_d   = arb_grant;
               psel_d  = win_req.pselx;
            end
         end
         SETUP: begin
            state_d   = ACCESS;
            penable_d = 1'b1;
         end
         ACCESS: begin
            if (m00_pready) begin
               state_d   = IDLE;
               gnt_d     = 2'b00;
               psel_d    = '0;
               penable_d = 1'b0;
            end
         end
         default: begin
            state_d   = IDLE;
            gnt_d     = 2'b00;
            psel_d    = '0;
            penable_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         req_q     <= '0;
         gnt_q     <= 2'b00;
         psel_q    <= '0;
         penable_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         gnt_q     <= gnt_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
      end
   end

   // Address/control/data hold their last value in IDLE; only psel/penable drop.
   assign m00_paddr   = req_q.paddr;
   assign m00_pprot   = req_q.pprot;
   assign m00_pwrite  = req_q.pwrite;
   assign m00_pwdata  = req_q.pwdata;
   assign m00_pstrb   = req_q.pstrb;
   assign m00_pselx   = psel_q;
   assign m00_penable = penable_q;

   generate
      for (gi = 0; gi < 2; gi++) begin : g_resp
         logic served;
         assign served          = (state_q == ACCESS) && gnt_q[gi];
         assign up_pready[gi]   = served & m00_pready;
         assign up_pslverr[gi]  = served & m00_pready & m00_pslverr;
         assign up_prdata[gi]   = (served && m00_pready && !req_q.pwrite) ? m00_prdata : '0;
      end
   endgenerate

   assign s00_pready  = up_pready[0];
   assign s00_pslverr = up_pslverr[0];
   assign s00_prdata  = up_prdata[0];
   assign s01_pready  = up_pready[1];
   assign s01_pslverr = up_pslverr[1];
   assign s01_prdata  = up_prdata[1];

endmodule

// File: tb/tb_apb_arbiter_2to1.sv
// Directed bench for apb_arbiter_2to1: expected downstream transfers are queued when a
// requester is driven and popped when the arbiter replays them on m00.
module tb_apb_arbiter_2to1;

   typedef struct {
      int          port;
      logic [31:0] paddr;
      logic [2:0]  pprot;
      logic [3:0]  pselx;
      logic        pwrite;
      logic [31:0] pwdata;
      logic [3:0]  pstrb;
   } exp_t;

   logic        clock = 1'b0;
   logic        resetn;

   logic [31:0] paddr   [2];
   logic [2:0]  pprot   [2];
   logic [3:0]  pselx   [2];
   logic        penable [2];
   logic        pwrite  [2];
   logic [31:0] pwdata  [2];
   logic [3:0]  pstrb   [2];

   logic        s00_pready, s00_pslverr, s01_pready, s01_pslverr;
   logic [31:0] s00_prdata, s01_prdata;

   logic [31:0] m00_paddr;
   logic [2:0]  m00_pprot;
   logic [3:0]  m00_pselx;
   logic        m00_penable, m00_pwrite;
   logic [31:0] m00_pwdata;
   logic [3:0]  m00_pstrb;
   logic        m00_pready, m00_pslverr;
   logic [31:0] m00_prdata;

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q [$];

   always #5 clock = ~clock;

   apb_arbiter_2to1 dut (
      .clock       (clock),
      .resetn      (resetn),
      .s00_paddr   (paddr[0]),
      .s00_pprot   (pprot[0]),
      .s00_pselx   (pselx[0]),
      .s00_penable (penable[0]),
      .s00_pwrite  (pwrite[0]),
      .s00_pwdata  (pwdata[0]),
      .s00_pstrb   (pstrb[0]),
      .s00_pready  (s00_pready),
      .s00_pslverr (s00_pslverr),
      .s00_prdata  (s00_prdata),
      .s01_paddr   (paddr[1]),
      .s01_pprot   (pprot[1]),
      .s01_pselx   (pselx[1]),
      .s01_penable (penable[1]),
      .s01_pwrite  (pwrite[1]),
      .s01_pwdata  (pwdata[1]),
      .s01_pstrb   (pstrb[1]),
      .s01_pready  (s01_pready),
      .s01_pslverr (s01_pslverr),
      .s01_prdata  (s01_prdata),
      .m00_paddr   (m00_paddr),
      .m00_pprot   (m00_pprot),
      .m00_pselx   (m00_pselx),
      .m00_penable (m00_penable),
      .m00_pwrite  (m00_pwrite),
      .m00_pwdata  (m00_pwdata),
      .m00_pstrb   (m00_pstrb),
      .m00_pready  (m00_pready),
      .m00_pslverr (m00_pslverr),
      .m00_prdata  (m00_prdata)
   );

   function automatic logic up_rdy(input int p);
      return (p == 1) ? s01_pready : s00_pready;
   endfunction
   function automatic logic up_err(input int p);
      return (p == 1) ? s01_pslverr : s00_pslverr;
   endfunction
   function automatic logic [31:0] up_rd(input int p);
      return (p == 1) ? s01_prdata : s00_prdata;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int p, input logic [31:0] a, input logic [2:0] prot,
                        input logic [3:0] sel, input logic wr, input logic [31:0] wd,
                        input logic [3:0] st);
      paddr[p]   = a;
      pprot[p]   = prot;
      pselx[p]   = sel;
      penable[p] = 1'b0;
      pwrite[p]  = wr;
      pwdata[p]  = wd;
      pstrb[p]   = st;
   endtask

   task automatic push_exp(input int p);
      exp_t e;
      e.port   = p;
      e.paddr  = paddr[p];
      e.pprot  = pprot[p];
      e.pselx  = pselx[p];
      e.pwrite = pwrite[p];
      e.pwdata = pwdata[p];
      e.pstrb  = pstrb[p];
      exp_q.push_back(e);
   endtask

   task automatic clear_inputs();
      for (int p = 0; p < 2; p++) drive(p, 32'h0, 3'h0, 4'h0, 1'b0, 32'h0, 4'h0);
      m00_pready  = 1'b0;
      m00_pslverr = 1'b0;
      m00_prdata  = 32'h0;
   endtask

   // Waits (bounded) for a downstream setup phase; lat counts edges taken.
   task automatic wait_setup(output bit ok, output int lat);
      ok  = 1'b0;
      lat = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clock);
         #1;
         lat++;
         if (m00_pselx != 4'h0 && !m00_penable) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic serve(input int waits, input logic [31:0] rdata, input logic err,
                        input int withdraw, input int exp_lat);
      exp_t e;
      bit   ok;
      int   lat;
      int   g;
      int   o;
      wait_setup(ok, lat);
      check("setup_seen", 32'(ok), 32'd1);
      if (!ok) return;
      if (exp_lat > 0) check("setup_latency", lat, exp_lat);
      check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() == 0) return;
      e = exp_q.pop_front();
      g = e.port;
      o = 1 - g;
      check("setup_paddr",   m00_paddr,          e.paddr);
      check("setup_pprot",   32'(m00_pprot),     32'(e.pprot));
      check("setup_pselx",   32'(m00_pselx),     32'(e.pselx));
      check("setup_pwrite",  32'(m00_pwrite),    32'(e.pwrite));
      check("setup_pwdata",  m00_pwdata,         e.pwdata);
      check("setup_pstrb",   32'(m00_pstrb),     32'(e.pstrb));
      check("setup_penable", 32'(m00_penable),   32'd0);
      check("setup_up_rdy",  32'(up_rdy(g)),     32'd0);
      @(posedge clock);
      #1;
      check("access_penable", 32'(m00_penable), 32'd1);
      check("access_pselx",   32'(m00_pselx),   32'(e.pselx));
      if (withdraw >= 0) pselx[withdraw] = 4'h0;
      for (int w = 0; w < waits; w++) begin
         check("wait_up_rdy",  32'(up_rdy(g)),   32'd0);
         check("wait_penable", 32'(m00_penable), 32'd1);
         @(posedge clock);
         #1;
      end
      m00_pready  = 1'b1;
      m00_pslverr = err;
      m00_prdata  = rdata;
      #1;
      check("done_up_rdy",    32'(up_rdy(g)), 32'd1);
      check("done_up_err",    32'(up_err(g)), 32'(err));
      check("done_up_rdata",  up_rd(g),       e.pwrite ? 32'h0 : rdata);
      check("done_paddr",     m00_paddr,      e.paddr);
      check("other_rdy",      32'(up_rdy(o)), 32'd0);
      check("other_err",      32'(up_err(o)), 32'd0);
      check("other_rdata",    up_rd(o),       32'h0);
      $display("xfer port=s0%0d addr=%h write=%0d wdata=%h rdata=%h err=%0d waits=%0d",
               g, e.paddr, e.pwrite, e.pwdata, up_rd(g), up_err(g), waits);
      @(posedge clock);
      #1;
      m00_pready  = 1'b0;
      m00_pslverr = 1'b0;
      m00_prdata  = 32'h0;
      check("after_up_rdy",  32'(up_rdy(g)),   32'd0);
      check("after_pselx",   32'(m00_pselx),   32'd0);
      check("after_penable", 32'(m00_penable), 32'd0);
      check("after_paddr",   m00_paddr,        e.paddr);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int lat;

      // Reset state.
      clear_inputs();
      resetn = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_m00_pselx",   32'(m00_pselx),   32'd0);
      check("rst_m00_penable", 32'(m00_penable), 32'd0);
      check("rst_m00_paddr",   m00_paddr,        32'h0);
      check("rst_m00_pwdata",  m00_pwdata,       32'h0);
      check("rst_s00_pready",  32'(s00_pready),  32'd0);
      check("rst_s01_pready",  32'(s01_pready),  32'd0);
      resetn = 1'b1;

      // Single write from s00, zero-wait downstream.
      drive(0, 32'h100, 3'h2, 4'h1, 1'b1, 32'hDEADBEEF, 4'hF);
      push_exp(0);
      serve(0, 32'hAAAA5555, 1'b0, -1, 1);
      pselx[0] = 4'h0;

      // Read from s01 with three wait states.
      drive(1, 32'h204, 3'h1, 4'h2, 1'b0, 32'h0, 4'h0);
      push_exp(1);
      serve(3, 32'h12345678, 1'b0, -1, 1);
      pselx[1] = 4'h0;

      // Contention after reset: strict alternation 00, 01, 00, 01.
      @(posedge clock);
      #1;
      resetn = 1'b0;
      @(posedge clock);
      #1;
      resetn = 1'b1;
      drive(0, 32'h1000, 3'h0, 4'h1, 1'b1, 32'h00000A00, 4'h3);
      drive(1, 32'h2000, 3'h0, 4'h4, 1'b1, 32'h00000B00, 4'hC);
      push_exp(0);
      push_exp(1);
      serve(0, 32'h0, 1'b0, -1, 1);
      drive(0, 32'h1004, 3'h0, 4'h1, 1'b0, 32'h0, 4'h0);
      push_exp(0);
      serve(0, 32'h0, 1'b0, -1, 1);
      drive(1, 32'h2004, 3'h0, 4'h8, 1'b0, 32'h0, 4'h0);
      push_exp(1);
      serve(1, 32'hCAFE0001, 1'b0, -1, 1);
      pselx[0] = 4'h0;
      serve(0, 32'hCAFE0002, 1'b0, -1, 1);
      pselx[1] = 4'h0;

      // Slave error on an s00 write.
      drive(0, 32'h300, 3'h0, 4'h1, 1'b1, 32'h0BADF00D, 4'hF);
      push_exp(0);
      serve(1, 32'h5A5A5A5A, 1'b1, -1, 1);
      pselx[0] = 4'h0;

      // Reset during ACCESS: in-flight s00 transfer aborted, s01 pending.
      drive(0, 32'h400, 3'h0, 4'h1, 1'b0, 32'h0, 4'h0);
      wait_setup(ok, lat);
      check("abort_setup_seen", 32'(ok), 32'd1);
      check("abort_setup_addr", m00_paddr, 32'h400);
      drive(1, 32'h500, 3'h0, 4'h2, 1'b0, 32'h0, 4'h0);
      @(posedge clock);
      #1;
      check("abort_in_access", 32'(m00_penable), 32'd1);
      m00_pready = 1'b1;
      m00_prdata = 32'h77777777;
      resetn     = 1'b0;
      #1;
      check("abort_m00_pselx",   32'(m00_pselx),   32'd0);
      check("abort_m00_penable", 32'(m00_penable), 32'd0);
      check("abort_m00_paddr",   m00_paddr,        32'h0);
      check("abort_s00_pready",  32'(s00_pready),  32'd0);
      check("abort_s00_prdata",  s00_prdata,       32'h0);
      check("abort_s01_pready",  32'(s01_pready),  32'd0);
      @(posedge clock);
      #1;
      m00_pready = 1'b0;
      m00_prdata = 32'h0;
      resetn     = 1'b1;
      push_exp(0);
      push_exp(1);
      serve(0, 32'h40404040, 1'b0, -1, 1);
      pselx[0] = 4'h0;
      serve(0, 32'h50505050, 1'b0, -1, 1);
      pselx[1] = 4'h0;

      // m00_pready while idle must not reach either requester.
      m00_pready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clock);
         #1;
         check("idle_s00_pready", 32'(s00_pready), 32'd0);
         check("idle_s01_pready", 32'(s01_pready), 32'd0);
         check("idle_m00_pselx",  32'(m00_pselx),  32'd0);
      end
      m00_pready = 1'b0;

      // s01 raises then withdraws while s00 is served: nothing more on m00.
      drive(0, 32'h600, 3'h0, 4'h1, 1'b1, 32'h66666666, 4'hF);
      drive(1, 32'h700, 3'h0, 4'h1, 1'b1, 32'h77777777, 4'hF);
      push_exp(0);
      serve(2, 32'h0, 1'b0, 1, 1);
      pselx[0] = 4'h0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clock);
         #1;
         check("withdrawn_no_xfer", 32'(m00_pselx), 32'd0);
      end
      check("sb_drained", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
